// File: rtl/rs_scheduler.sv
// Reservation-station scheduler: lowest-free allocation, round-robin issue grant
// held under valid/ready, clear strobes. Optional macro RS_SAME_CYCLE_REUSE_EN.
module rs_scheduler #(
    parameter int unsigned RS_SIZE = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [RS_SIZE-1:0]           busy_in,
    input  logic [RS_SIZE-1:0]           ready_in,
    input  logic                         dispatch_valid,
    input  logic                         fu_ready,
    input  logic                         squash,
    output logic [RS_SIZE-1:0]           wr_en,
    output logic [RS_SIZE-1:0]           clear,
    output logic                         dispatch_stall,
    output logic                         rs_full,
    output logic [$clog2(RS_SIZE+1)-1:0] free_count,
    output logic                         iss_valid,
    output logic [$clog2(RS_SIZE)-1:0]   iss_idx
);

    localparam int unsigned IDX_W = $clog2(RS_SIZE);
    localparam int unsigned CNT_W = $clog2(RS_SIZE + 1);

    logic [IDX_W-1:0]   rr_ptr;
    logic               valid_n;
    logic [IDX_W-1:0]   idx_n;
    logic [IDX_W-1:0]   ptr_n;
    logic               fire;
    logic [RS_SIZE-1:0] issue_oh;
    logic [RS_SIZE-1:0] free;
    logic [RS_SIZE-1:0] cand;
    logic               found;
    logic [IDX_W-1:0]   pick;
    logic [IDX_W-1:0]   probe;
    logic [CNT_W-1:0]   cnt;

    assign fire     = iss_valid && fu_ready && !squash;
    assign issue_oh = RS_SIZE'(1) << iss_idx;

    // Clear strobes; reset masks them so a dropped grant never clears its entry
    always_comb begin
        clear = '0;
        if (reset) begin
            if (squash)
                clear = busy_in;
            else if (fire)
                clear = issue_oh;
        end
    end

    always_comb begin
`ifdef RS_SAME_CYCLE_REUSE_EN
        free = ~busy_in | clear;
`else
        free = ~busy_in;
`endif
    end

    always_comb begin
        cnt = '0;
        for (int unsigned i = 0; i < RS_SIZE; i++)
            cnt = cnt + CNT_W'(free[i]);
    end

    // Allocation: isolate lowest set bit of the free vector
    always_comb begin
        wr_en = '0;
        if (reset && dispatch_valid && !squash)
            wr_en = free & (~free + RS_SIZE'(1));
        free_count     = cnt;
        rs_full        = (cnt == '0);
        dispatch_stall = dispatch_valid && (free == '0);
    end

    // Round-robin search starting at rr_ptr; the held grant is never re-picked
    always_comb begin
        cand  = busy_in & ready_in & ~(iss_valid ? issue_oh : '0);
        found = 1'b0;
        pick  = '0;
        probe = '0;
        for (int unsigned k = 0; k < RS_SIZE; k++) begin
            probe = rr_ptr + IDX_W'(k);
            if (!found && cand[probe]) begin
                found = 1'b1;
                pick  = probe;
            end
        end
    end

    always_comb begin
        valid_n = iss_valid;
        idx_n   = iss_idx;
        ptr_n   = rr_ptr;
        if (squash) begin
            valid_n = 1'b0;
            idx_n   = '0;
            ptr_n   = '0;
        end else if (!iss_valid || fire) begin
            if (found) begin
                valid_n = 1'b1;
                idx_n   = pick;
                ptr_n   = pick + IDX_W'(1);
            end else begin
                valid_n = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            iss_valid <= 1'b0;
            iss_idx   <= '0;
            rr_ptr    <= '0;
        end else begin
            iss_valid <= valid_n;
            iss_idx   <= idx_n;
            rr_ptr    <= ptr_n;
        end
    end

endmodule

// File: tb/tb_rs_scheduler.sv
// Bench for rs_scheduler (RS_SIZE=4): directed vector table, hand-written
// reset sequences, and random stimulus against a behavioural model.
module tb_rs_scheduler;

    logic       clock;
    logic       reset;
    logic [3:0] busy_in;
    logic [3:0] ready_in;
    logic       dispatch_valid;
    logic       fu_ready;
    logic       squash;
    logic [3:0] wr_en;
    logic [3:0] clear;
    logic       dispatch_stall;
    logic       rs_full;
    logic [2:0] free_count;
    logic       iss_valid;
    logic [1:0] iss_idx;

    rs_scheduler #(.RS_SIZE(4)) dut (
        .clock(clock), .reset(reset), .busy_in(busy_in), .ready_in(ready_in),
        .dispatch_valid(dispatch_valid), .fu_ready(fu_ready), .squash(squash),
        .wr_en(wr_en), .clear(clear), .dispatch_stall(dispatch_stall),
        .rs_full(rs_full), .free_count(free_count), .iss_valid(iss_valid),
        .iss_idx(iss_idx)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int popc(input logic [3:0] v);
        int c = 0;
        for (int i = 0; i < 4; i++) c += int'(v[i]);
        return c;
    endfunction

    // ---------------- behavioural reference model ----------------
    int m_valid, m_idx, m_ptr;

    function automatic int rr_choose(input logic [3:0] b, input logic [3:0] r,
                                     input int held_valid, input int held_idx, input int start);
        for (int k = 0; k < 4; k++) begin
            int j;
            j = (start + k) % 4;
            if (b[j] && r[j] && !(held_valid == 1 && j == held_idx)) return j;
        end
        return -1;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_valid <= 0; m_idx <= 0; m_ptr <= 0;
        end else if (squash) begin
            m_valid <= 0; m_idx <= 0; m_ptr <= 0;
        end else if (m_valid == 0 || fu_ready) begin
            int p;
            p = rr_choose(busy_in, ready_in, m_valid, m_idx, m_ptr);
            if (p >= 0) begin
                m_valid <= 1; m_idx <= p; m_ptr <= (p + 1) % 4;
            end else begin
                m_valid <= 0;
            end
        end
    end

    task automatic model_comb(output logic [3:0] e_wr, output logic [3:0] e_clr,
                              output logic e_stall, output int e_fc);
        logic [3:0] fv;
        e_clr = 4'b0;
        if (reset) begin
            if (squash) e_clr = busy_in;
            else if (m_valid == 1 && fu_ready) e_clr = 4'(1 << m_idx);
        end
        fv = ~busy_in;
`ifdef RS_SAME_CYCLE_REUSE_EN
        fv = fv | e_clr;
`endif
        e_fc    = popc(fv);
        e_stall = dispatch_valid && (e_fc == 0);
        e_wr    = 4'b0;
        if (reset && dispatch_valid && !squash)
            for (int i = 3; i >= 0; i--) if (fv[i]) e_wr = 4'(1 << i);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [3:0] busy, ready;
        logic       dv, fr, sq;
        logic [3:0] wr, clr;
        logic       stall;
        int         fc;
        logic       valid;
        int         idx;   // -1: not checked
    } vec_t;

    vec_t vt[23];

    function automatic vec_t mk(input logic [3:0] b, input logic [3:0] r, input logic dv,
                                input logic fr, input logic sq, input logic [3:0] wr,
                                input logic [3:0] clr, input logic st, input int fc,
                                input logic v, input int idx);
        vec_t t;
        t.busy = b; t.ready = r; t.dv = dv; t.fr = fr; t.sq = sq;
        t.wr = wr; t.clr = clr; t.stall = st; t.fc = fc; t.valid = v; t.idx = idx;
        return t;
    endfunction

    logic [3:0] e_wr, e_clr;
    logic       e_stall;
    int         e_fc;

    initial begin
        // sequential allocation
        vt[0]  = mk(4'b0000, 4'b0000, 1, 0, 0, 4'b0001, 4'b0000, 0, 4, 0, -1);
        vt[1]  = mk(4'b0001, 4'b0000, 1, 0, 0, 4'b0010, 4'b0000, 0, 3, 0, -1);
        vt[2]  = mk(4'b0011, 4'b0000, 1, 0, 0, 4'b0100, 4'b0000, 0, 2, 0, -1);
        vt[3]  = mk(4'b0111, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 0, -1);
        // round robin, back-to-back issue with wrap
        vt[4]  = mk(4'b1111, 4'b1111, 0, 1, 0, 4'b0000, 4'b0000, 0, 0, 0, -1);
        vt[5]  = mk(4'b1111, 4'b1111, 0, 1, 0, 4'b0000, 4'b0001, 0, 0, 1, 0);
        vt[6]  = mk(4'b1111, 4'b1111, 0, 1, 0, 4'b0000, 4'b0010, 0, 0, 1, 1);
        vt[7]  = mk(4'b1111, 4'b1111, 0, 1, 0, 4'b0000, 4'b0100, 0, 0, 1, 2);
        vt[8]  = mk(4'b1111, 4'b1111, 0, 1, 0, 4'b0000, 4'b1000, 0, 0, 1, 3);
        vt[9]  = mk(4'b1111, 4'b1111, 0, 1, 0, 4'b0000, 4'b0001, 0, 0, 1, 0);
        // grant hold on entry 2
        vt[10] = mk(4'b1111, 4'b0100, 0, 1, 0, 4'b0000, 4'b0010, 0, 0, 1, 1);
        vt[11] = mk(4'b1111, 4'b0100, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 1, 2);
        vt[12] = mk(4'b1111, 4'b0100, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 1, 2);
        vt[13] = mk(4'b1111, 4'b0100, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 1, 2);
        vt[14] = mk(4'b1111, 4'b0100, 0, 1, 0, 4'b0000, 4'b0100, 0, 0, 1, 2);
        vt[15] = mk(4'b1011, 4'b0100, 0, 1, 0, 4'b0000, 4'b0000, 0, 1, 0, -1);
        // full RS, fire on entry 1
        vt[16] = mk(4'b1111, 4'b0010, 1, 1, 0, 4'b0000, 4'b0000, 1, 0, 0, -1);
`ifdef RS_SAME_CYCLE_REUSE_EN
        vt[17] = mk(4'b1111, 4'b0010, 1, 1, 0, 4'b0010, 4'b0010, 0, 0, 1, 1);
`else
        vt[17] = mk(4'b1111, 4'b0010, 1, 1, 0, 4'b0000, 4'b0010, 1, 0, 1, 1);
`endif
        vt[18] = mk(4'b1101, 4'b0000, 1, 1, 0, 4'b0010, 4'b0000, 0, 1, 0, -1);
        // squash during fire and dispatch; pointer must restart at 0
        vt[19] = mk(4'b1011, 4'b0001, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 0, -1);
        vt[20] = mk(4'b1011, 4'b0001, 1, 1, 1, 4'b0000, 4'b1011, 0, 1, 1, 0);
        vt[21] = mk(4'b1011, 4'b1011, 0, 1, 0, 4'b0000, 4'b0000, 0, 1, 0, 0);
        vt[22] = mk(4'b1011, 4'b1011, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 1, 0);

        // reset: registers cleared, strobes masked, counts follow inputs
        reset = 1'b0;
        busy_in = 4'b1010; ready_in = 4'b1010;
        dispatch_valid = 1'b1; fu_ready = 1'b1; squash = 1'b1;
        #2;
        chk("rst_iss_valid", int'(iss_valid), 0);
        chk("rst_iss_idx", int'(iss_idx), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_clear", int'(clear), 0);
        chk("rst_free_count", int'(free_count), 2);
        chk("rst_rs_full", int'(rs_full), 0);
        busy_in = 4'b0; ready_in = 4'b0;
        dispatch_valid = 1'b0; fu_ready = 1'b0; squash = 1'b0;
        #10 reset = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 23; i++) begin
            int fc;
            busy_in = vt[i].busy; ready_in = vt[i].ready;
            dispatch_valid = vt[i].dv; fu_ready = vt[i].fr; squash = vt[i].sq;
            fc = vt[i].fc;
`ifdef RS_SAME_CYCLE_REUSE_EN
            fc = popc(~vt[i].busy | vt[i].clr);
`endif
            #1;
            chk($sformatf("vec%0d_wr_en", i), int'(wr_en), int'(vt[i].wr));
            chk($sformatf("vec%0d_clear", i), int'(clear), int'(vt[i].clr));
            chk($sformatf("vec%0d_stall", i), int'(dispatch_stall), int'(vt[i].stall));
            chk($sformatf("vec%0d_free_count", i), int'(free_count), fc);
            chk($sformatf("vec%0d_rs_full", i), int'(rs_full), int'(fc == 0));
            chk($sformatf("vec%0d_iss_valid", i), int'(iss_valid), int'(vt[i].valid));
            if (vt[i].idx >= 0)
                chk($sformatf("vec%0d_iss_idx", i), int'(iss_idx), vt[i].idx);
            @(negedge clock);
        end

        // async reset while a grant is held and would fire
        busy_in = 4'b1011; ready_in = 4'b0000;
        dispatch_valid = 1'b1; fu_ready = 1'b1; squash = 1'b0;
        #1;
        chk("pre_rst_clear", int'(clear), 4'b0001);
        chk("pre_rst_iss_valid", int'(iss_valid), 1);
        #1 reset = 1'b0;
        #1;
        chk("midrst_iss_valid", int'(iss_valid), 0);
        chk("midrst_iss_idx", int'(iss_idx), 0);
        chk("midrst_clear", int'(clear), 0);
        chk("midrst_wr_en", int'(wr_en), 0);
        chk("midrst_free_count", int'(free_count), 1);
        fu_ready = 1'b0;
        #1 reset = 1'b1;
        @(negedge clock);
        #1;
        chk("postrst_iss_valid", int'(iss_valid), 0);
        chk("postrst_clear", int'(clear), 0);
        @(negedge clock);

        // random stimulus against the model
        for (int n = 0; n < 400; n++) begin
            busy_in        = 4'($urandom);
            ready_in       = 4'($urandom);
            dispatch_valid = 1'($urandom_range(0, 1));
            fu_ready       = ($urandom_range(0, 3) != 0);
            squash         = ($urandom_range(0, 15) == 0);
            #1;
            model_comb(e_wr, e_clr, e_stall, e_fc);
            chk("rnd_wr_en", int'(wr_en), int'(e_wr));
            chk("rnd_clear", int'(clear), int'(e_clr));
            chk("rnd_stall", int'(dispatch_stall), int'(e_stall));
            chk("rnd_free_count", int'(free_count), e_fc);
            chk("rnd_rs_full", int'(rs_full), int'(e_fc == 0));
            chk("rnd_iss_valid", int'(iss_valid), m_valid);
            if (m_valid == 1) chk("rnd_iss_idx", int'(iss_idx), m_idx);
            @(negedge clock);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
